// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: command sequencer for an external combinational 8-bit ALU.
// Owns a 4 x DW register file and takes one command at a time over
// cmd_valid/cmd_ready. ALU commands may repeat, with the result fed back as
// operand A. OP_LOAD writes an immediate. Unknown codes complete with err=1.
// Optional feature macro: ALU_SEQ_ZFLAG_EN adds a registered zero flag output.
module alu_seq_ctrl #(
    parameter int          DW         = 8,
    parameter int          NUM_OPS    = 10,
    parameter logic [3:0]  OP_LOAD    = 4'b1111,
    parameter logic [3:0]  IDLE_OPSEL = 4'b1000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [3:0]    cmd_op,
    input  logic [1:0]    cmd_dst,
    input  logic [1:0]    cmd_srca,
    input  logic [1:0]    cmd_srcb,
    input  logic [DW-1:0] cmd_imm,
    input  logic [2:0]    cmd_rep,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_opsel,
    input  logic [DW-1:0] alu_f,
    output logic          done,
    output logic          err,
`ifdef ALU_SEQ_ZFLAG_EN
    output logic          zflag,
`endif
    output logic [DW-1:0] res_data
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t        state_r, state_nx_s;

    logic [DW-1:0] rf_r    [4];
    logic [DW-1:0] rf_nx_s [4];

    logic [DW-1:0] alu_a_r, alu_a_nx_s;
    logic [DW-1:0] alu_b_r, alu_b_nx_s;
    logic [3:0]    opsel_r, opsel_nx_s;
    logic [1:0]    dst_r, dst_nx_s;
    logic [1:0]    srcb_r, srcb_nx_s;
    logic [2:0]    rep_r, rep_nx_s;
    logic          err_r, err_nx_s;
    logic [DW-1:0] res_r, res_nx_s;
    logic          done_r;
    logic          ready_r;
    logic          op_legal_s;

    // Opsel codes 0..NUM_OPS-1 are forwarded to the ALU; anything else is not.
    assign op_legal_s = ({1'b0, cmd_op} < 5'(NUM_OPS));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state decode: ALU ops run EXEC for rep+1 cycles, others go straight to DONE.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (op_legal_s) begin
                        state_nx_s = ST_EXEC;
                    end else begin
                        state_nx_s = ST_DONE;
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (rep_r == 3'd0) begin
                    state_nx_s = ST_DONE;
                end else begin
                    state_nx_s = ST_EXEC;
                end
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Datapath next values: operand launch, write-back, repeat feedback and status.
    always_comb begin
        rf_nx_s    = rf_r;
        alu_a_nx_s = alu_a_r;
        alu_b_nx_s = alu_b_r;
        opsel_nx_s = opsel_r;
        dst_nx_s   = dst_r;
        srcb_nx_s  = srcb_r;
        rep_nx_s   = rep_r;
        err_nx_s   = err_r;
        res_nx_s   = res_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (op_legal_s) begin
                        // Operands read the pre-write register file.
                        alu_a_nx_s = rf_r[cmd_srca];
                        alu_b_nx_s = rf_r[cmd_srcb];
                        opsel_nx_s = cmd_op;
                        dst_nx_s   = cmd_dst;
                        srcb_nx_s  = cmd_srcb;
                        rep_nx_s   = cmd_rep;
                    end else if (cmd_op == OP_LOAD) begin
                        rf_nx_s[cmd_dst] = cmd_imm;
                        res_nx_s         = cmd_imm;
                        err_nx_s         = 1'b0;
                    end else begin
                        // Illegal code: only the error status changes.
                        err_nx_s = 1'b1;
                    end
                end else begin
                    rep_nx_s = rep_r;
                end
            end
            ST_EXEC: begin
                rf_nx_s[dst_r] = alu_f;
                res_nx_s       = alu_f;
                if (rep_r != 3'd0) begin
                    rep_nx_s   = rep_r - 3'd1;
                    alu_a_nx_s = alu_f;
                    // Post-write view, so srcb==dst picks up the fresh result.
                    alu_b_nx_s = rf_nx_s[srcb_r];
                end else begin
                    err_nx_s = 1'b0;
                end
            end
            ST_DONE: begin
                err_nx_s = err_r;
            end
            default: begin
                err_nx_s = err_r;
            end
        endcase
    end

    // Datapath and handshake registers; outputs are all driven from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                rf_r[i] <= {DW{1'b0}};
            end
            alu_a_r <= {DW{1'b0}};
            alu_b_r <= {DW{1'b0}};
            opsel_r <= IDLE_OPSEL;
            dst_r   <= 2'd0;
            srcb_r  <= 2'd0;
            rep_r   <= 3'd0;
            err_r   <= 1'b0;
            res_r   <= {DW{1'b0}};
            done_r  <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                rf_r[i] <= rf_nx_s[i];
            end
            alu_a_r <= alu_a_nx_s;
            alu_b_r <= alu_b_nx_s;
            opsel_r <= opsel_nx_s;
            dst_r   <= dst_nx_s;
            srcb_r  <= srcb_nx_s;
            rep_r   <= rep_nx_s;
            err_r   <= err_nx_s;
            res_r   <= res_nx_s;
            done_r  <= (state_nx_s == ST_DONE);
            ready_r <= (state_nx_s == ST_IDLE);
        end
    end

`ifdef ALU_SEQ_ZFLAG_EN
    logic zflag_r, zflag_nx_s;

    // Zero flag follows the value written by the command on the edge into DONE.
    always_comb begin
        zflag_nx_s = zflag_r;
        case (state_r)
            ST_IDLE: begin
                if (cmd_valid && !op_legal_s && (cmd_op == OP_LOAD)) begin
                    zflag_nx_s = (cmd_imm == {DW{1'b0}});
                end else begin
                    zflag_nx_s = zflag_r;
                end
            end
            ST_EXEC: begin
                if (rep_r == 3'd0) begin
                    zflag_nx_s = (alu_f == {DW{1'b0}});
                end else begin
                    zflag_nx_s = zflag_r;
                end
            end
            default: zflag_nx_s = zflag_r;
        endcase
    end

    // Zero flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zflag_r <= 1'b0;
        end else begin
            zflag_r <= zflag_nx_s;
        end
    end

    assign zflag = zflag_r;
`endif

    assign cmd_ready = ready_r;
    assign alu_a     = alu_a_r;
    assign alu_b     = alu_b_r;
    assign alu_opsel = opsel_r;
    assign done      = done_r;
    assign err       = err_r;
    assign res_data  = res_r;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Testbench for alu_seq_ctrl: behavioural ALU + register-file reference model,
// expectations queued at command issue and checked by an independent monitor
// whenever done pulses.
module tb_alu_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [3:0] cmd_op;
    logic [1:0] cmd_dst, cmd_srca, cmd_srcb;
    logic [7:0] cmd_imm;
    logic [2:0] cmd_rep;
    logic [7:0] alu_a, alu_b, alu_f, res_data;
    logic [3:0] alu_opsel;
    logic       done, err;
`ifdef ALU_SEQ_ZFLAG_EN
    logic       zflag;
`endif

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [7:0] res;
        logic       err;
        logic       z;
        int         due;
    } exp_t;
    exp_t sb_q[$];

    // Reference state
    logic [7:0] m_rf [4];
    logic [7:0] m_res;
    logic       m_err;
    logic       m_z;
    logic [3:0] m_opsel;

    localparam logic [3:0] LOAD = 4'b1111;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural ALU: 0 add,1 sub,2 and,3 or,4 xor,5 inca,6 shal,7 nega(zero test),8 passa,9 passb
    function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a + 8'd1;
            4'd6: return {a[6:0], 1'b0};
            4'd7: return (a == 8'h00) ? 8'h01 : 8'h00;
            4'd8: return a;
            4'd9: return b;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_f = alu_fn(alu_opsel, alu_a, alu_b);

    alu_seq_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
        .cmd_imm(cmd_imm), .cmd_rep(cmd_rep),
        .alu_a(alu_a), .alu_b(alu_b), .alu_opsel(alu_opsel), .alu_f(alu_f),
        .done(done), .err(err),
`ifdef ALU_SEQ_ZFLAG_EN
        .zflag(zflag),
`endif
        .res_data(res_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
        m_res   = 8'h00;
        m_err   = 1'b0;
        m_z     = 1'b0;
        m_opsel = 4'b1000;
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("res_data", {24'd0, res_data}, {24'd0, e.res});
                chk("err", {31'd0, err}, {31'd0, e.err});
                chk("done_cycle", cyc, e.due);
`ifdef ALU_SEQ_ZFLAG_EN
                chk("zflag", {31'd0, zflag}, {31'd0, e.z});
`endif
            end
        end
    end

    // Issue one command, update the model, and check ALU drive during EXEC.
    task automatic issue(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] srca,
                         input logic [1:0] srcb, input logic [7:0] imm, input logic [2:0] rep,
                         input bit hold, input int abort_at, output int acc);
        logic [7:0] a, b, r;
        logic [7:0] ea[$];
        logic [7:0] eb[$];
        exp_t e;
        int n;
        bit is_alu;
        @(negedge clk);
        cmd_op = op; cmd_dst = dst; cmd_srca = srca; cmd_srcb = srcb;
        cmd_imm = imm; cmd_rep = rep; cmd_valid = 1'b1;
        n = 0;
        while (cmd_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            chk("ready_timeout", 32'd0, 32'd1);
            cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        acc = cyc;
        is_alu = (op < 4'd10);
        r = 8'h00;
        if (is_alu) begin
            a = m_rf[srca];
            b = m_rf[srcb];
            for (int i = 0; i <= int'(rep); i++) begin
                ea.push_back(a);
                eb.push_back(b);
                r = alu_fn(op, a, b);
                m_rf[dst] = r;
                a = r;
                b = m_rf[srcb];
            end
            m_res = r; m_err = 1'b0; m_z = (r == 8'h00); m_opsel = op;
            e.due = acc + 2 + int'(rep);
        end else if (op == LOAD) begin
            m_rf[dst] = imm; m_res = imm; m_err = 1'b0; m_z = (imm == 8'h00);
            e.due = acc + 1;
        end else begin
            m_err = 1'b1;
            e.due = acc + 1;
        end
        e.res = m_res; e.err = m_err; e.z = m_z;
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        if (!hold) cmd_valid = 1'b0;
        if (is_alu) begin
            for (int i = 0; i <= int'(rep); i++) begin
                if (abort_at > 0 && i == abort_at) begin
                    cmd_valid = 1'b0;
                    rst_n = 1'b0;
                    sb_q.delete();
                    model_reset();
                    @(negedge clk);
                    chk("abort_done_low", {31'd0, done}, 32'd0);
                    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
                    rst_n = 1'b1;
                    @(negedge clk);
                    chk("post_rst_ready", {31'd0, cmd_ready}, 32'd1);
                    chk("post_rst_res", {24'd0, res_data}, 32'd0);
                    chk("post_rst_opsel", {28'd0, alu_opsel}, 32'd8);
                    return;
                end
                chk("exec_alu_a", {24'd0, alu_a}, {24'd0, ea[i]});
                chk("exec_alu_b", {24'd0, alu_b}, {24'd0, eb[i]});
                chk("exec_opsel", {28'd0, alu_opsel}, {28'd0, op});
                chk("exec_ready_low", {31'd0, cmd_ready}, 32'd0);
                if (i < int'(rep)) @(negedge clk);
            end
        end else begin
            chk("done_ready_low", {31'd0, cmd_ready}, 32'd0);
            chk("hold_opsel", {28'd0, alu_opsel}, {28'd0, m_opsel});
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc1, acc2, acc;
        logic [3:0] op;
        int sel;
        cmd_valid = 1'b0; cmd_op = 4'd0; cmd_dst = 2'd0; cmd_srca = 2'd0; cmd_srcb = 2'd0;
        cmd_imm = 8'h00; cmd_rep = 3'd0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
        chk("rst_opsel", {28'd0, alu_opsel}, 32'd8);
        chk("rst_alu_a", {24'd0, alu_a}, 32'd0);
        chk("rst_alu_b", {24'd0, alu_b}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_res", {24'd0, res_data}, 32'd0);
        rst_n = 1'b1;

        // Load then add: 5 + 3 = 8, then read r2 back through passa
        issue(LOAD, 2'd0, 2'd0, 2'd0, 8'h05, 3'd0, 1'b0, 0, acc);
        issue(LOAD, 2'd1, 2'd0, 2'd0, 8'h03, 3'd5, 1'b0, 0, acc);
        issue(4'd0, 2'd2, 2'd0, 2'd1, 8'h00, 3'd0, 1'b0, 0, acc);
        issue(4'd8, 2'd3, 2'd2, 2'd2, 8'h00, 3'd0, 1'b0, 0, acc);
        // shal r0 three times: 05 -> 0A -> 14 -> 28
        issue(4'd6, 2'd0, 2'd0, 2'd0, 8'h00, 3'd2, 1'b0, 0, acc);
        // inca wrap to zero
        issue(LOAD, 2'd0, 2'd0, 2'd0, 8'hFF, 3'd0, 1'b0, 0, acc);
        issue(4'd5, 2'd1, 2'd0, 2'd0, 8'h00, 3'd0, 1'b0, 0, acc);
        // Illegal code: err, nothing else changes
        issue(4'b1100, 2'd1, 2'd0, 2'd0, 8'h77, 3'd0, 1'b0, 0, acc);
        issue(4'd8, 2'd2, 2'd1, 2'd1, 8'h00, 3'd0, 1'b0, 0, acc);
        // srcb == dst feedback across repeats
        issue(4'd0, 2'd3, 2'd0, 2'd3, 8'h00, 3'd3, 1'b0, 0, acc);
        // Reset in the middle of a long command
        issue(4'd0, 2'd2, 2'd0, 2'd1, 8'h00, 3'd7, 1'b0, 3, acc);
        // Register file must read back as zero after the reset
        issue(4'd3, 2'd0, 2'd2, 2'd3, 8'h00, 3'd0, 1'b0, 0, acc);
        // Held cmd_valid: back-to-back LOADs every 2 cycles, ALU op in between
        issue(LOAD, 2'd1, 2'd0, 2'd0, 8'h11, 3'd0, 1'b1, 0, acc1);
        issue(LOAD, 2'd2, 2'd0, 2'd0, 8'h22, 3'd0, 1'b1, 0, acc2);
        chk("b2b_load_spacing", acc2 - acc1, 32'd2);
        issue(4'd4, 2'd3, 2'd1, 2'd2, 8'h00, 3'd1, 1'b1, 0, acc1);
        issue(LOAD, 2'd0, 2'd0, 2'd0, 8'h00, 3'd0, 1'b1, 0, acc2);
        chk("alu_throughput", acc2 - acc1, 32'd4);

        // Randomized commands against the model
        for (int k = 0; k < 60; k++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 2) op = LOAD;
            else if (sel == 2) op = 4'($urandom_range(10, 14));
            else op = 4'($urandom_range(0, 9));
            issue(op, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  8'($urandom), 3'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, acc);
        end

        cmd_valid = 1'b0;
        for (int w = 0; w < 50 && sb_q.size() > 0; w++) @(negedge clk);
        chk("drain", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
Name: alu_seq_ctrl

Overview:
Command sequencer for the 8-bit `alu` datapath. It owns a 4-entry x 8-bit register file and accepts one command at a time over a valid/ready handshake. For each command it drives the ALU operand and opsel inputs, samples the ALU result, and writes it back. A command can repeat its operation N extra times, with the result fed back as operand A. It sits between a host/test driver and one combinational `alu` instance.

Parameters:
DW, 8, data width of the register file and ALU operands
NUM_OPS, 10, legal ALU opsel codes are 0 .. NUM_OPS-1
OP_LOAD, 4'b1111, command code that writes cmd_imm to the register file with no ALU use
IDLE_OPSEL, 4'b1000, opsel driven after reset (passa)

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high exactly when state==IDLE
cmd_op  in  4  ALU opsel, or OP_LOAD
cmd_dst  in  2  destination register index
cmd_srca  in  2  operand A register index
cmd_srcb  in  2  operand B register index
cmd_imm  in  DW  immediate value for OP_LOAD
cmd_rep  in  3  extra repetitions (total applications = cmd_rep+1)
alu_a  out  DW  registered, to alu.a
alu_b  out  DW  registered, to alu.b
alu_opsel  out  4  registered, to alu.opsel
alu_f  in  DW  from alu.f (combinational)
done  out  1  one-cycle pulse when a command completes
err  out  1  valid with done; 1 = illegal op
res_data  out  DW  value written by the command; held until the next done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; rf[0..3]=0.
  - alu_a=0, alu_b=0, alu_opsel=IDLE_OPSEL.
  - done=0, err=0, res_data=0, rep counter=0.
  - Reset mid-command aborts it; no write or done occurs.
- States: IDLE, EXEC, DONE.
- IDLE:
  - Command is accepted on the clock edge where cmd_valid && cmd_ready.
  - cmd_op < NUM_OPS: load alu_a=rf[srca], alu_b=rf[srcb], alu_opsel=cmd_op; latch dst, srcb and rep; go to EXEC.
  - cmd_op==OP_LOAD: rf[dst]=cmd_imm on the same edge; res_data=cmd_imm; err=0; go to DONE; cmd_rep is ignored.
  - Any other code: no write, ALU outputs unchanged, err=1, res_data unchanged; go to DONE.
- EXEC:
  - Each cycle, alu_f is written into rf[dst] and res_data at the clock edge.
  - If rep != 0: decrement rep; alu_a=alu_f; alu_b=rf[srcb] post-write (equals alu_f if srcb==dst); stay in EXEC.
  - If rep == 0: go to DONE with err=0.
- DONE:
  - done=1 for exactly one cycle; cmd_ready=0; go to IDLE.
- Latency: with acceptance at edge T, done is high in cycle T+2+cmd_rep for ALU ops and T+1 for LOAD or illegal codes.
- Throughput: one command per cmd_rep+3 cycles (LOAD: 2 cycles).
- Arithmetic and width:
  - All results are DW bits; overflow wraps, because the ALU truncates.
  - The controller does not interpret the result; e.g. nega yields 0/1.
- cmd_valid, cmd_op and the other command fields are ignored outside IDLE.
- The ALU outputs hold their last values in IDLE and DONE.
- srca==dst, srcb==dst and srca==srcb are all legal; reads return pre-write values on the acceptance edge.

Optional Feature:
Macro: ALU_SEQ_ZFLAG_EN.
- Defined:
  - Adds output zflag (1 bit), reset 0.
  - Updated at the edge that enters DONE: 1 if the value written is 0, else 0.
  - Illegal commands leave it unchanged.
- Undefined: the zflag port and its logic are absent; all other behaviour is identical.

Test Plan:
1. LOAD r0=0x05, then LOAD r1=0x03, then addab dst=r2 srca=r0 srcb=r1 rep=0 -> done 2 cycles after acceptance, res_data=0x08, err=0, rf[2]=0x08.
2. shal dst=r0 srca=r0 rep=2 with r0=0x05 -> three applications; done at T+4; res_data=0x28; alu_a sequence 0x05, 0x0A, 0x14.
3. LOAD r0=0xFF; inca dst=r1 srca=r0 -> res_data=0x00 (wrap); zflag=1 when ALU_SEQ_ZFLAG_EN is defined.
4. cmd_op=4'b1100 -> done at T+1 with err=1; rf, res_data and alu_opsel unchanged.
5. addab rep=7; deassert rst_n at T+3 -> state IDLE, rf all 0, no done pulse, cmd_ready=1 after reset release.
6. Hold cmd_valid high through a command -> second command accepted only in IDLE (cmd_ready=0 during EXEC and DONE); back-to-back LOADs complete every 2 cycles.
